pwm_driver: RTL and testbench

Converts the 7-bit duty word from the power control loop into a complementary, dead-time-protected PWM pair for the heater/power stage. It also produces a period-start strobe and a mid-on-time ADC sample strobe for the power measurement path that closes the loop. Duty is double-buffered, so loop updates take effect only at period boundaries. Disabling the block lets the current period finish before it parks both outputs low.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_deadtime.sv | 55 +++++
 rtl/pwm_driver.sv | 105 ++++++++++
 tb/tb_pwm_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg : shared state encoding and defaults for the PWM driver   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pwm_pkg;

  localparam int c_DUTY_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } pwm_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_deadtime : complementary output stage with dead-time insertion |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pwm_deadtime #(
  parameter int DEAD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic active,
  output logic pwm_h,
  output logic pwm_l
);

  localparam int c_DW = (DEAD < 2) ? 1 : $clog2(DEAD + 1);

  logic            r_raw_d;
  logic [c_DW-1:0] r_dead;
  logic            r_pwm_h;
  logic            r_pwm_l;
  logic            w_edge;

  assign w_edge = raw ^ r_raw_d;

  // r_dead holds the remaining low cycles; the selected side is driven on
  // the cycle after it reaches 1 so the gap is exactly DEAD clocks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_raw_d <= 1'b0;
      r_dead  <= '0;
      r_pwm_h <= 1'b0;
      r_pwm_l <= 1'b0;
    end else begin
      r_raw_d <= raw;
      if (w_edge && (DEAD != 0)) begin
        r_dead  <= c_DW'(DEAD);
        r_pwm_h <= 1'b0;
        r_pwm_l <= 1'b0;
      end else if (r_dead > c_DW'(1)) begin
        r_dead <= r_dead - 1'b1;
      end else begin
        r_dead  <= '0;
        r_pwm_h <= raw;
        r_pwm_l <= !raw && active;
      end
    end
  end

  assign pwm_h = r_pwm_h;
  assign pwm_l = r_pwm_l;

endmodule
`default_nettype wire

// File: rtl/pwm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_driver : double-buffered duty PWM with dead-time and strobes   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = c_DUTY_W_DEFAULT,
  parameter int PRESCALE = 4,
  parameter int DEAD     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_h,
  output logic              pwm_l,
  output logic              period_start,
  output logic              sample,
  output logic              active
);

  localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  pwm_state_t        r_state;
  logic [c_PW-1:0]   r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_duty_sh;
  logic              r_period_start;
  logic              r_sample;

  logic w_active;
  logic w_tick;
  logic w_wrap;
  logic w_raw;

  assign w_active = (r_state != IDLE);
  assign w_tick   = w_active && (r_pre == c_PW'(PRESCALE - 1));
  assign w_wrap   = w_tick && (r_cnt == '1);
  assign w_raw    = w_active && (r_cnt < r_duty_sh);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_pre          <= '0;
      r_cnt          <= '0;
      r_duty_sh      <= '0;
      r_period_start <= 1'b0;
      r_sample       <= 1'b0;
    end else begin
      r_period_start <= w_active && (r_cnt == '0) && (r_pre == '0);
      r_sample       <= w_active && (r_duty_sh != '0) && (r_pre == '0) &&
                        (r_cnt == (r_duty_sh >> 1));

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= RUN;
            r_duty_sh <= duty;
          end
        end
        RUN: begin
          if (!enable) r_state <= STOPPING;
          if (w_wrap)  r_duty_sh <= duty;
        end
        STOPPING: begin
          // A re-request wins over the final wrap so operation stays seamless.
          if (enable) begin
            r_state <= RUN;
            if (w_wrap) r_duty_sh <= duty;
          end else if (w_wrap) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_active) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_pre <= '0;
        r_cnt <= '0;
      end
    end
  end

  pwm_deadtime #(
    .DEAD (DEAD)
  ) u_deadtime (
    .clk    (clk),
    .reset  (reset),
    .raw    (w_raw),
    .active (w_active),
    .pwm_h  (pwm_h),
    .pwm_l  (pwm_l)
  );

  assign period_start = r_period_start;
  assign sample       = r_sample;
  assign active       = w_active;

endmodule
`default_nettype wire

// File: tb/tb_pwm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwm_driver : self-checking bench for pwm_driver (defaults)      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pwm_driver;

  localparam int c_PERIOD = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] duty = 7'd0;
  logic       pwm_h, pwm_l, period_start, sample, active;

  always #5 clk = ~clk;

  pwm_driver #(
    .DUTY_W   (7),
    .PRESCALE (4),
    .DEAD     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty         (duty),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .period_start (period_start),
    .sample       (sample),
    .active       (active)
  );

  typedef struct {
    int duty;
    int h;
    int l;
    int s;
  } vec_t;

  typedef struct {
    int h;
    int l;
    int s;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.h = v.h;
    e.l = v.l;
    e.s = v.s;
    sb.push_back(e);
  endtask

  // Per-period monitor: a window runs from one period_start pulse to the next,
  // or to the cycle where active is seen low.
  bit mon_en = 1'b1;
  bit in_win = 1'b0;
  int m_pos, m_h, m_l, m_ov, m_s;

  task automatic finalize();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("window_len", m_pos, c_PERIOD);
      check("pwm_h_len", m_h, e.h);
      check("pwm_l_len", m_l, e.l);
      check("sample_offset", m_s, e.s);
      check("overlap_cycles", m_ov, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      in_win = 1'b0;
    end else begin
      if (period_start) begin
        if (in_win) finalize();
        in_win = 1'b1;
        m_pos = 0; m_h = 0; m_l = 0; m_ov = 0; m_s = -1;
      end
      if (in_win) begin
        if (pwm_h) m_h++;
        if (pwm_l) m_l++;
        if (pwm_h && pwm_l) m_ov++;
        if (sample) m_s = (m_s == -1) ? m_pos : -2;
        m_pos++;
        if (!active) begin
          finalize();
          in_win = 1'b0;
        end
      end
    end
  end

  task automatic wait_ps(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!period_start && t < 700);
    if (!period_start) check(name, 0, 1);
  endtask

  // Runs until active drops, dropping enable at 'drop_at' cycles; returns
  // the cycle count measured from the period_start negedge.
  task automatic stop_after(input int drop_at, output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == drop_at) enable = 1'b0;
    end while (active && t < 700);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t v100, v64;
    int   t, cnt_ps;

    // {duty, pwm_h clk, pwm_l clk, sample offset from period_start (-1: none)}
    tbl[0] = '{64, 254, 254, 128};
    tbl[1] = '{64, 254, 254, 128};
    tbl[2] = '{64, 254, 254, 128};
    tbl[3] = '{0, 0, 512, -1};
    tbl[4] = '{127, 506, 2, 252};
    tbl[5] = '{1, 2, 506, 0};
    tbl[6] = '{32, 126, 382, 64};
    tbl[7] = '{64, 254, 254, 128};
    v100   = '{100, 398, 110, 200};
    v64    = '{64, 254, 254, 128};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({pwm_h, pwm_l, period_start, sample, active}), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outputs", int'({pwm_h, pwm_l, period_start, sample, active}), 0);

    // Table-driven run: each record is one full period.
    duty = 7'(tbl[0].duty);
    push_exp(tbl[0]);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_ps("period_start_timeout_tbl");
      duty = 7'(tbl[i + 1].duty);
      push_exp(tbl[i + 1]);
    end

    // Duty change mid-period only lands on the following period.
    wait_ps("period_start_timeout_mid");
    push_exp(v100);
    repeat (40) @(negedge clk);
    duty = 7'd100;

    // Enable dropped then re-raised within the same period: seamless.
    wait_ps("period_start_timeout_reen");
    push_exp(v100);
    repeat (80) @(negedge clk);
    enable = 1'b0;
    repeat (120) @(negedge clk);
    enable = 1'b1;

    // Enable dropped at cnt~20 and left low: period completes, then idle.
    wait_ps("period_start_timeout_stop");
    stop_after(80, t);
    check("active_fall_cycle", t, 511);
    cnt_ps = 0;
    repeat (20) begin
      @(negedge clk);
      if (period_start) cnt_ps++;
    end
    check("stopped_outputs", int'({pwm_h, pwm_l, sample, active}), 0);
    check("stopped_no_period_start", cnt_ps, 0);
    check("scoreboard_empty_after_stop", sb.size(), 0);

    // Reset while pwm_h is high.
    duty = 7'd64;
    push_exp(v64);
    enable = 1'b1;
    wait_ps("period_start_timeout_rst");
    t = 0;
    while (!pwm_h && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pwm_h_high_before_reset", int'(pwm_h), 1);
    mon_en = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", int'({pwm_h, pwm_l, period_start, sample, active}), 0);
    sb.delete();
    reset = 1'b1;
    push_exp(v64);
    mon_en = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!period_start && t < 10);
    check("restart_period_start_delay", t, 2);
    stop_after(80, t);
    check("restart_active_fall_cycle", t, 511);
    repeat (3) @(negedge clk);
    check("scoreboard_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
